// File: rtl/shared_mac_scheduler.sv
// shared_mac_scheduler: round-robin shared pipelined signed multiplier with per-requester accumulators
module shared_mac_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int A_BITS      = 24,
  parameter int B_BITS      = 24,
  parameter int ACC_BITS    = 56,
  parameter int MUL_LATENCY = 3
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*A_BITS-1:0]  a_i,
  input  logic [NUM_REQ*B_BITS-1:0]  b_i,
  input  logic [NUM_REQ-1:0]         first_i,
  input  logic [NUM_REQ-1:0]         last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic signed [ACC_BITS-1:0] result_o,
  output logic [NUM_REQ-1:0]         result_valid_o
);
  localparam int TW = $clog2(NUM_REQ);
  localparam int L  = MUL_LATENCY;
  logic [TW-1:0] ptr, gidx;
  logic [A_BITS-1:0] a_sel;
  logic [B_BITS-1:0] b_sel;
  logic f_sel, l_sel;
  logic [L-1:0] v, f, l;
  logic [TW-1:0] tag [L];
  logic signed [A_BITS-1:0] a_r;
  logic signed [B_BITS-1:0] b_r;
  logic signed [A_BITS+B_BITS-1:0] mul;
  logic signed [ACC_BITS-1:0] prod [L-1];
  logic signed [ACC_BITS-1:0] acc [NUM_REQ];
  logic signed [ACC_BITS-1:0] acc_nxt;
  int idx;
  always_comb begin
    gnt_o = '0;
    gidx  = '0;
    a_sel = '0;
    b_sel = '0;
    f_sel = 1'b0;
    l_sel = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i >= NUM_REQ ? int'(ptr) + i - NUM_REQ : int'(ptr) + i;
      if (!reset && gnt_o == '0 && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gidx  = TW'(idx);
        a_sel = a_i[idx*A_BITS +: A_BITS];
        b_sel = b_i[idx*B_BITS +: B_BITS];
        f_sel = first_i[idx];
        l_sel = last_i[idx];
      end
    end
  end
  assign mul = (A_BITS+B_BITS)'(a_r) * (A_BITS+B_BITS)'(b_r);
  // Accumulation happens only in the last stage, in grant order, so acc[k] is always the newest value
  assign acc_nxt = f[L-1] ? prod[L-2] : acc[tag[L-1]] + prod[L-2];
  always_ff @(posedge clk_i) begin
    if (reset) begin
      ptr            <= '0;
      v              <= '0;
      result_o       <= '0;
      result_valid_o <= '0;
      for (int k = 0; k < NUM_REQ; k++) acc[k] <= '0;
    end else begin
      v              <= {v[L-2:0], |gnt_o};
      result_valid_o <= '0;
      if (|gnt_o) ptr <= gidx == TW'(NUM_REQ-1) ? '0 : gidx + 1'b1;
      if (v[L-1]) begin
        acc[tag[L-1]] <= acc_nxt;
        if (l[L-1]) begin
          result_o                    <= acc_nxt;
          result_valid_o[tag[L-1]]    <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    f       <= {f[L-2:0], f_sel};
    l       <= {l[L-2:0], l_sel};
    tag[0]  <= gidx;
    for (int j = 1; j < L; j++) tag[j] <= tag[j-1];
    a_r     <= a_sel;
    b_r     <= b_sel;
    prod[0] <= ACC_BITS'(mul);
    for (int j = 1; j < L-1; j++) prod[j] <= prod[j-1];
  end
endmodule
